fifo_stream_reader: RTL and testbench

- Downstream stage of the DPRAM-based FIFO.
- Converts the FIFO's pull interface (empty flag, read enable, registered read data arriving RD_LATENCY cycles later) into a valid/ready stream.
- Prefetches from the FIFO and hides the RAM read latency with a small output buffer, so it sustains one word per clock when the consumer is always ready.
- Provides a synchronous flush that discards buffered and in-flight words.

---
 rtl/fifo_stream_reader_pkg.sv | 15 +
 rtl/stream_out_buf.sv | 58 +++++
 rtl/fifo_stream_reader.sv | 72 +++++++
 tb/tb_fifo_stream_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared helpers for the FIFO stream reader: latency bound and in-flight counting.
package fifo_stream_reader_pkg;

  localparam int MAX_RD_LATENCY = 3;

  function automatic logic [1:0] count_ones(input logic [MAX_RD_LATENCY-1:0] bits);
    logic [1:0] n;
    n = '0;
    for (int i = 0; i < MAX_RD_LATENCY; i++) begin
      n = n + {1'b0, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/stream_out_buf.sv
// Circular output buffer: push at the tail, pop at the head, synchronous flush.
module stream_out_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH = 2,
  localparam int LVL_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [LVL_W-1:0]  level,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Turns the FIFO pull interface into a valid/ready stream, prefetching enough
// words to cover the RAM read latency so a ready consumer gets one word per clock.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RD_LATENCY = 1,
  localparam int BUF_DEPTH = RD_LATENCY + 1,
  localparam int LVL_W = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  input  logic              i_flush,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_busy
);

  localparam int OCC_W = LVL_W + 1;

  logic [RD_LATENCY-1:0] rd_pipe;
  logic [LVL_W-1:0]      level;
  logic [1:0]            inflight;
  logic [OCC_W-1:0]      occ;
  logic [OCC_W-1:0]      occ_after_pop;
  logic                  pop;
  logic                  capture;

  assign pop      = m_valid && m_ready;
  assign inflight = count_ones(MAX_RD_LATENCY'(rd_pipe));
  assign occ      = OCC_W'(level) + OCC_W'(inflight);
  assign occ_after_pop = occ - OCC_W'(pop);

  // Counting in-flight reads against the buffer space is what makes overflow impossible.
  assign fifo_rd_en = rst && !fifo_empty && !i_flush && (occ_after_pop < OCC_W'(BUF_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pipe <= '0;
    end else if (i_flush) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | RD_LATENCY'(fifo_rd_en);
    end
  end

  assign capture = rd_pipe[RD_LATENCY-1] && !i_flush;

  stream_out_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (fifo_data),
    .pop       (pop),
    .flush     (i_flush),
    .level     (level),
    .head_data (m_data)
  );

  assign m_valid = (level != '0);
  assign o_level = level;
  assign o_busy  = (level != '0) || (rd_pipe != '0);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader at read latencies 1 and 3, sharing one source word list.
module tb_fifo_stream_reader;

  localparam int DATA_W = 16;
  localparam int SRC_N  = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold_empty = 1'b1;
  logic m_ready = 1'b1;
  logic i_flush = 1'b0;

  logic [1:0]             fifo_empty;
  logic [1:0]             fifo_rd_en;
  logic [1:0]             m_valid;
  logic [1:0]             o_busy;
  logic [1:0][DATA_W-1:0] fifo_data;
  logic [1:0][DATA_W-1:0] m_data;
  logic [1:0][2:0]        o_level;

  logic [DATA_W-1:0] src_mem [SRC_N];
  int src_wr = 0;
  int src_rd [2] = '{0, 0};
  int checks = 0;
  int failures = 0;
  int delivered [2] = '{0, 0};

  logic [DATA_W-1:0] out_q [2][$];
  logic [DATA_W-1:0] dline [2][$];

  always #5 clk = ~clk;

  assign fifo_empty[0] = hold_empty || (src_rd[0] == src_wr);
  assign fifo_empty[1] = hold_empty || (src_rd[1] == src_wr);
  assign o_level[0][2] = 1'b0;

  fifo_stream_reader #(.DATA_W(DATA_W), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_rd_en(fifo_rd_en[0]),
    .fifo_data(fifo_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
    .i_flush(i_flush), .o_level(o_level[0][1:0]), .o_busy(o_busy[0])
  );

  fifo_stream_reader #(.DATA_W(DATA_W), .RD_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_rd_en(fifo_rd_en[1]),
    .fifo_data(fifo_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
    .i_flush(i_flush), .o_level(o_level[1]), .o_busy(o_busy[1])
  );

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    src_mem[src_wr] = w;
    src_wr++;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      tick();
      done = (src_rd[0] == src_wr) && (src_rd[1] == src_wr) && (o_busy == 2'b00);
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  // Reference model: a word becomes outstanding when read from the FIFO and
  // leaves when popped or flushed; the stream must always present the oldest one.
  initial begin : monitor
    logic s_rst, s_flush;
    logic s_rd [2];
    logic s_vld [2];
    logic s_pop [2];
    logic hold [2];
    logic [DATA_W-1:0] s_data [2];
    logic [DATA_W-1:0] hold_data [2];
    logic [DATA_W-1:0] w;
    for (int g = 0; g < 2; g++) begin
      hold[g] = 1'b0;
      hold_data[g] = '0;
      fifo_data[g] = '0;
      for (int i = 0; i < lat_of(g) - 1; i++) dline[g].push_back('0);
    end
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_flush = i_flush;
      for (int g = 0; g < 2; g++) begin
        s_rd[g]   = fifo_rd_en[g];
        s_vld[g]  = m_valid[g];
        s_pop[g]  = m_valid[g] && m_ready;
        s_data[g] = m_data[g];
        if (!s_rst) begin
          out_q[g].delete();
          dline[g].delete();
          for (int i = 0; i < lat_of(g) - 1; i++) dline[g].push_back('0);
          hold[g] = 1'b0;
        end else begin
          if (s_rd[g]) chk($sformatf("rd_en_while_empty[%0d]", g), 32'(fifo_empty[g]), 32'd0);
          if (s_flush) chk($sformatf("rd_en_in_flush[%0d]", g), 32'(s_rd[g]), 32'd0);
          if (hold[g]) begin
            chk($sformatf("stall_valid[%0d]", g), 32'(s_vld[g]), 32'd1);
            chk($sformatf("stall_data[%0d]", g), 32'(s_data[g]), 32'(hold_data[g]));
          end
          if (s_vld[g]) begin
            chk($sformatf("valid_has_word[%0d]", g), 32'(out_q[g].size() != 0), 32'd1);
            if (out_q[g].size() != 0)
              chk($sformatf("head_data[%0d]", g), 32'(s_data[g]), 32'(out_q[g][0]));
          end
          hold[g] = s_vld[g] && !m_ready && !s_flush;
          hold_data[g] = s_data[g];
        end
      end
      @(posedge clk);
      #1;
      if (s_rst) begin
        for (int g = 0; g < 2; g++) begin
          if (s_pop[g] && out_q[g].size() != 0) begin
            void'(out_q[g].pop_front());
            delivered[g]++;
          end
          if (s_flush) out_q[g].delete();
          if (s_rd[g] && src_rd[g] != src_wr) begin
            w = src_mem[src_rd[g]];
            src_rd[g]++;
            out_q[g].push_back(w);
            dline[g].push_back(w);
          end else begin
            dline[g].push_back(DATA_W'($urandom));
          end
          fifo_data[g] = dline[g].pop_front();
          chk($sformatf("occ_bound[%0d]", g), 32'(out_q[g].size() <= lat_of(g) + 1), 32'd1);
          chk($sformatf("level_bound[%0d]", g), 32'(int'(o_level[g]) <= lat_of(g) + 1), 32'd1);
          chk($sformatf("busy[%0d]", g), 32'(o_busy[g]), 32'(out_q[g].size() != 0));
        end
      end
    end
  end

  initial begin : stimulus
    bit [1:0] got;
    int d0 [2];
    #1;
    rst = 1'b0;

    // Reset held with a non-empty FIFO and a ready consumer.
    push_word(16'h5A5A);
    hold_empty = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("rst_rd_en[%0d]", g), 32'(fifo_rd_en[g]), 32'd0);
        chk($sformatf("rst_valid[%0d]", g), 32'(m_valid[g]), 32'd0);
        chk($sformatf("rst_data[%0d]", g), 32'(m_data[g]), 32'd0);
        chk($sformatf("rst_level[%0d]", g), 32'(o_level[g]), 32'd0);
        chk($sformatf("rst_busy[%0d]", g), 32'(o_busy[g]), 32'd0);
      end
    end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    for (int g = 0; g < 2; g++) chk($sformatf("post_rst_word[%0d]", g), 32'(delivered[g]), 32'd1);

    // Single word: first valid RD_LATENCY+1 cycles after the read pulse.
    hold_empty = 1'b1;
    push_word(16'hA5A5);
    tick();
    hold_empty = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) chk($sformatf("single_rd_en[%0d]", g), 32'(fifo_rd_en[g]), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1)
        for (int g = 0; g < 2; g++) chk($sformatf("single_rd_drop[%0d]", g), 32'(fifo_rd_en[g]), 32'd0);
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("single_valid[%0d]@%0d", g, c), 32'(m_valid[g]), 32'(c == lat_of(g) + 1));
        if (c == lat_of(g) + 1) chk($sformatf("single_data[%0d]", g), 32'(m_data[g]), 32'hA5A5);
      end
    end
    hold_empty = 1'b1;

    // Streaming eight words with the consumer always ready.
    for (int i = 1; i <= 8; i++) push_word(DATA_W'(i));
    tick();
    hold_empty = 1'b0;
    #1;
    for (int c = 0; c < 12; c++) begin
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("stream_rd_en[%0d]@%0d", g, c), 32'(fifo_rd_en[g]), 32'(c < 8));
        chk($sformatf("stream_valid[%0d]@%0d", g, c), 32'(m_valid[g]),
            32'(c >= lat_of(g) + 1 && c <= lat_of(g) + 8));
        if (c >= lat_of(g) + 1 && c <= lat_of(g) + 8)
          chk($sformatf("stream_data[%0d]@%0d", g, c), 32'(m_data[g]), 32'(c - lat_of(g)));
      end
      tick();
      #1;
    end

    // Backpressure mid-stream.
    hold_empty = 1'b1;
    for (int g = 0; g < 2; g++) d0[g] = delivered[g];
    for (int i = 0; i < 12; i++) push_word(DATA_W'(16'h0100 + i));
    tick();
    hold_empty = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    m_ready = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("bp_rd_en[%0d]", g), 32'(fifo_rd_en[g]), 32'd0);
      chk($sformatf("bp_level[%0d]", g), 32'(o_level[g]), 32'(lat_of(g) + 1));
      chk($sformatf("bp_valid[%0d]", g), 32'(m_valid[g]), 32'd1);
    end
    m_ready = 1'b1;
    drain("bp_drain");
    for (int g = 0; g < 2; g++)
      chk($sformatf("bp_count[%0d]", g), 32'(delivered[g] - d0[g]), 32'd12);

    // Flush with reads in flight.
    hold_empty = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) push_word(DATA_W'(16'h0200 + i));
    tick();
    hold_empty = 1'b0;
    tick();
    tick();
    chk("flush_pre_level[0]", 32'(o_level[0]), 32'd1);
    chk("flush_pre_level[1]", 32'(o_level[1]), 32'd0);
    for (int g = 0; g < 2; g++) chk($sformatf("flush_pre_busy[%0d]", g), 32'(o_busy[g]), 32'd1);
    i_flush = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) chk($sformatf("flush_rd_en[%0d]", g), 32'(fifo_rd_en[g]), 32'd0);
    tick();
    i_flush = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("flush_valid[%0d]", g), 32'(m_valid[g]), 32'd0);
      chk($sformatf("flush_level[%0d]", g), 32'(o_level[g]), 32'd0);
      chk($sformatf("flush_busy[%0d]", g), 32'(o_busy[g]), 32'd0);
    end
    m_ready = 1'b1;
    got = 2'b00;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int g = 0; g < 2; g++) begin
        if (m_valid[g] && !got[g]) begin
          got[g] = 1'b1;
          chk($sformatf("flush_next_word[%0d]", g), 32'(m_data[g]), 32'h0202);
        end
      end
    end
    chk("flush_resume", 32'(got), 32'd3);

    // Reset mid-stream clears everything at once.
    rst = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("midrst_rd_en[%0d]", g), 32'(fifo_rd_en[g]), 32'd0);
      chk($sformatf("midrst_valid[%0d]", g), 32'(m_valid[g]), 32'd0);
      chk($sformatf("midrst_data[%0d]", g), 32'(m_data[g]), 32'd0);
      chk($sformatf("midrst_level[%0d]", g), 32'(o_level[g]), 32'd0);
      chk($sformatf("midrst_busy[%0d]", g), 32'(o_busy[g]), 32'd0);
    end
    tick();
    tick();
    rst = 1'b1;
    drain("midrst_drain");

    // Random traffic with stalls, empty gaps and occasional flushes.
    for (int i = 0; i < 200; i++) push_word(DATA_W'($urandom));
    for (int c = 0; c < 400; c++) begin
      tick();
      m_ready    = ($urandom_range(0, 9) < 7);
      hold_empty = ($urandom_range(0, 9) < 2);
      i_flush    = ($urandom_range(0, 31) == 0);
    end
    i_flush = 1'b0;
    hold_empty = 1'b0;
    m_ready = 1'b1;
    drain("random_drain");
    for (int g = 0; g < 2; g++) chk($sformatf("final_valid[%0d]", g), 32'(m_valid[g]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
